// File: rtl/kudu_dv_pkg.sv
// Shared DV memory types for the kudu bench: transaction record, region map,
// log flag bit positions and the memory arbiter state encoding.
package kudu_dv_pkg;

  localparam logic [31:0] DRAMStartAddr  = 32'h8000_0000;
  localparam logic [31:0] TsMapStartAddr = 32'h8300_0000;

  localparam int FlagPortId  = 0;
  localparam int FlagDecErr  = 1;
  localparam int FlagTimeout = 2;
  localparam int FlagTsMap   = 3;

  typedef struct packed {
    logic [7:0]  flag;
    logic        is_cap;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr32;
    logic [64:0] wdata;
    logic [64:0] rdata;
    logic        err;
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Offset form avoids overflow when start + size wraps past 2^32.
  function automatic logic is_dram(input logic [31:0] addr, input logic [31:0] size);
    return (addr >= DRAMStartAddr) && ((addr - DRAMStartAddr) < size);
  endfunction

  function automatic logic is_tsmap(input logic [31:0] addr, input logic [31:0] size);
    return (addr >= TsMapStartAddr) && ((addr - TsMapStartAddr) < size);
  endfunction

endpackage

// File: rtl/kudu_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen; the winner is remembered only when a grant is actually issued.
module kudu_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       win_id_o
);

  logic r_last_winner;
  logic w_win_id;

  always_comb begin
    w_win_id = 1'b0;
    if (req_i == 2'b11) begin
      w_win_id = ~r_last_winner;
    end else begin
      w_win_id = req_i[1];
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    if (en_i && (req_i != 2'b00)) begin
      gnt_o = w_win_id ? 2'b10 : 2'b01;
    end else begin
      gnt_o = 2'b00;
    end
  end

  assign win_id_o = w_win_id;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_winner <= 1'b1;
    end else if (en_i && (req_i != 2'b00)) begin
      r_last_winner <= w_win_id;
    end
  end

endmodule

// File: rtl/kudu_mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one simulated memory port,
// one transaction in flight, and emits a mem_cmd_t log record per completion.
module kudu_mem_arbiter
  import kudu_dv_pkg::*;
#(
  parameter logic [31:0] DramSize      = 32'h0100_0000,
  parameter logic [31:0] TsMapSize     = 32'h0008_0000,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_i,
  input  logic [1:0]                   we_i,
  input  logic [1:0]                   is_cap_i,
  input  logic [1:0][3:0]              be_i,
  input  logic [1:0][29:0]             addr32_i,
  input  logic [1:0][64:0]             wdata_i,
  output logic [1:0]                   gnt_o,
  output logic [1:0]                   rvalid_o,
  output logic [64:0]                  rdata_o,
  output logic                         err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [29:0]                  mem_addr32_o,
  output logic [64:0]                  mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [64:0]                  mem_rdata_i,
  input  logic                         mem_err_i,
  output logic                         cmd_valid_o,
  output logic [$bits(mem_cmd_t)-1:0]  cmd_o
);

  localparam int unsigned     CntW    = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  arb_state_e r_state;
  arb_state_e w_next_state;

  logic        w_arb_en;
  logic        w_win_id;
  logic [1:0]  w_win_gnt;
  logic [31:0] w_byte_addr;
  logic        w_in_dram;
  logic        w_in_tsmap;
  logic        w_legal;
  logic [7:0]  w_init_flag;
  mem_cmd_t    w_cmd;

  logic            r_id;
  logic            r_we;
  logic            r_is_cap;
  logic [3:0]      r_be;
  logic [29:0]     r_addr32;
  logic [64:0]     r_wdata;
  logic [64:0]     r_rdata;
  logic            r_err;
  logic [7:0]      r_flag;
  logic [CntW-1:0] r_cnt;

  // Reset gates the picker so no grant leaks out during the reset cycle.
  assign w_arb_en = (r_state == ARB_IDLE) && !rst_i;

  kudu_rr_arb2 u_rr_arb2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (w_arb_en),
    .req_i    (req_i),
    .gnt_o    (w_win_gnt),
    .win_id_o (w_win_id)
  );

  assign gnt_o       = w_win_gnt;
  assign w_byte_addr = {addr32_i[w_win_id], 2'b00};
  assign w_in_dram   = is_dram(w_byte_addr, DramSize);
  assign w_in_tsmap  = is_tsmap(w_byte_addr, TsMapSize);
  assign w_legal     = w_in_dram || w_in_tsmap;

  always_comb begin
    w_init_flag             = 8'h00;
    w_init_flag[FlagPortId] = w_win_id;
    w_init_flag[FlagDecErr] = ~w_legal;
    w_init_flag[FlagTsMap]  = w_in_tsmap;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_win_gnt != 2'b00) begin
          w_next_state = w_legal ? ARB_ISSUE : ARB_RESP;
        end else begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (mem_gnt_i) begin
          w_next_state = mem_rvalid_i ? ARB_RESP : ARB_WAIT;
        end else begin
          w_next_state = ARB_ISSUE;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid_i || (r_cnt == CntLast)) begin
          w_next_state = ARB_RESP;
        end else begin
          w_next_state = ARB_WAIT;
        end
      end
      ARB_RESP: w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ARB_IDLE;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_is_cap <= 1'b0;
      r_be     <= 4'h0;
      r_addr32 <= 30'd0;
      r_wdata  <= 65'd0;
      r_rdata  <= 65'd0;
      r_err    <= 1'b0;
      r_flag   <= 8'h00;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ARB_IDLE: begin
          if (w_win_gnt != 2'b00) begin
            r_id     <= w_win_id;
            r_we     <= we_i[w_win_id];
            r_is_cap <= is_cap_i[w_win_id];
            r_be     <= be_i[w_win_id];
            r_addr32 <= addr32_i[w_win_id];
            // Plain word accesses carry only 32 meaningful data bits.
            r_wdata  <= is_cap_i[w_win_id] ? wdata_i[w_win_id]
                                           : {33'd0, wdata_i[w_win_id][31:0]};
            r_rdata  <= 65'd0;
            r_err    <= ~w_legal;
            r_flag   <= w_init_flag;
            r_cnt    <= '0;
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt_i) begin
            r_cnt <= '0;
            if (mem_rvalid_i) begin
              r_rdata <= r_we ? 65'd0 : mem_rdata_i;
              r_err   <= mem_err_i;
            end
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid_i) begin
            r_rdata <= r_we ? 65'd0 : mem_rdata_i;
            r_err   <= mem_err_i;
          end else if (r_cnt == CntLast) begin
            r_rdata             <= 65'd0;
            r_err               <= 1'b1;
            r_flag[FlagTimeout] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory-side and response-side outputs are decoded from registered state only.
  always_comb begin
    rvalid_o     = 2'b00;
    rdata_o      = 65'd0;
    err_o        = 1'b0;
    cmd_valid_o  = 1'b0;
    w_cmd        = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'h0;
    mem_addr32_o = 30'd0;
    mem_wdata_o  = 65'd0;
    case (r_state)
      ARB_ISSUE: begin
        mem_req_o    = 1'b1;
        mem_we_o     = r_we;
        mem_be_o     = r_be;
        mem_addr32_o = r_addr32;
        mem_wdata_o  = r_wdata;
      end
      ARB_RESP: begin
        rvalid_o[r_id] = 1'b1;
        rdata_o        = r_rdata;
        err_o          = r_err;
        cmd_valid_o    = 1'b1;
        w_cmd.flag     = r_flag;
        w_cmd.is_cap   = r_is_cap;
        w_cmd.we       = r_we;
        w_cmd.be       = r_be;
        w_cmd.addr32   = r_addr32;
        w_cmd.wdata    = r_wdata;
        w_cmd.rdata    = r_rdata;
        w_cmd.err      = r_err;
      end
      default: begin
      end
    endcase
  end

  assign cmd_o = w_cmd;

endmodule

// File: doc/kudu_mem_arbiter.md
Name: kudu_mem_arbiter

Overview:
- Arbitrates two DV memory requesters (port 0 = instruction fetch, port 1 = data/capability load-store) onto a single simulated memory port.
- Sequences each transaction through a request/grant/response FSM with one transaction outstanding.
- Decodes DRAM vs tag-map (TsMap) regions and flags illegal addresses.
- Emits one kudu_dv_pkg::mem_cmd_t record per completed transaction to the bench scoreboard/logger.

Parameters:
- DramSize, 32'h0100_0000, byte size of the DRAM window starting at DRAMStartAddr.
- TsMapSize, 32'h0008_0000, byte size of the tag-map window starting at TsMapStartAddr.
- TimeoutCycles, 64, maximum cycles in WAIT before a forced error response; must be at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- req_i  in  [1:0]  per-port request; held high until gnt_o
- we_i  in  [1:0]  per-port write enable
- is_cap_i  in  [1:0]  per-port capability (65-bit) access
- be_i  in  [1:0][3:0]  per-port byte enables
- addr32_i  in  [1:0][29:0]  per-port word address
- wdata_i  in  [1:0][64:0]  per-port write data
- gnt_o  out  [1:0]  one-cycle accept pulse
- rvalid_o  out  [1:0]  one-cycle response pulse
- rdata_o  out  65  response data, shared by both ports
- err_o  out  1  response error, qualified by rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr32_o  out  30  memory word address
- mem_wdata_o  out  65  memory write data
- mem_gnt_i  in  1  memory accept
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  65  memory read data
- mem_err_i  in  1  memory error
- cmd_valid_o  out  1  log record valid (one cycle)
- cmd_o  out  $bits(mem_cmd_t)  completed-transaction record

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE; last_winner = 1, so port 0 wins first on a tie; timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Any req_i set: pick the winner. With a single request, that port wins. With both, the port != last_winner wins.
  - Assert gnt_o[winner] for that one cycle.
  - Capture the winner's id, we, is_cap, be, addr32 and wdata into a transaction register; last_winner <= winner.
  - Decode the byte address {addr32,2'b00}:
    - In [DRAMStartAddr, +DramSize): DRAM region.
    - In [TsMapStartAddr, +TsMapSize): tag-map region; set flag[3].
    - Otherwise: decode error; set flag[1] and go to RESP with err=1 and rdata=0. No memory access is made.
  - Legal address: go to ISSUE.
- ISSUE:
  - mem_req_o = 1 with the captured fields; they stay stable until mem_gnt_i.
  - On mem_gnt_i: go to WAIT and clear the counter.
  - mem_rvalid_i in the same cycle as mem_gnt_i is legal: capture it and go straight to RESP.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid_i: capture mem_rdata_i and mem_err_i, then go to RESP.
  - If the counter reaches TimeoutCycles-1 without mem_rvalid_i: err=1, rdata=0, set flag[2], go to RESP.
  - A later stray mem_rvalid_i is ignored.
- RESP (exactly one cycle):
  - rvalid_o[id] = 1; rdata_o/err_o = captured values.
  - cmd_valid_o = 1.
  - Return to IDLE.
  - A new grant is possible no earlier than the cycle after RESP.
- Latency:
  - Minimum request to response: gnt at T, ISSUE at T+1; with zero-wait memory (gnt and rvalid both at T+1), rvalid_o at T+2.
  - Decode error: rvalid_o at T+1.
- cmd_o fields at RESP:
  - flag[0] = port id; flag[1] = decode error; flag[2] = timeout; flag[3] = tag-map region; flag[7:4] = 0.
  - is_cap, we, be, addr32, wdata: captured values.
  - rdata, err: response values.
  - rdata = 0 for writes.
- Width rules:
  - Non-capability accesses use wdata[31:0]; the arbiter forces bits [64:32] to 0 on capture.
  - Read data passes through unmodified.
- Requests that drop before grant are ignored; no grant is issued to a deasserted req.
- rst_i asserted mid-transaction (ISSUE/WAIT/RESP):
  - Next cycle the FSM is in IDLE and all outputs are 0.
  - No rvalid_o and no cmd_valid_o are produced for the aborted transaction.
  - A late mem_rvalid_i after reset is ignored.

Decomposition:
- Add to kudu_dv_pkg:
  - region decode function is_dram(addr)/is_tsmap(addr) using DRAMStartAddr/TsMapStartAddr.
  - flag bit index constants (FlagPortId=0, FlagDecErr=1, FlagTimeout=2, FlagTsMap=3).
  - arb_state_e enum.
- Reuse the existing mem_cmd_t unchanged.
- One sub-module: kudu_rr_arb2 (2-way round-robin pick with last_winner register; ~30 lines).

Test Plan:
- Single read, port 0, addr32=30'h2000_0000 (byte 8000_0000), memory gnt+rvalid at same cycle with rdata=65'h1_DEAD_BEEF_0000_0001 -> gnt_o[0] at T, rvalid_o[0] at T+2, cmd_o.flag=8'h00, rdata matches.
- Both ports request every cycle for 8 transactions -> grants strictly alternate 0,1,0,1…, port 0 first after reset.
- Port 1 write to byte addr 8300_0010, is_cap=0, wdata=65'h1_FFFF_FFFF_1234_5678 -> mem_wdata_o=65'h0_0000_0000_1234_5678, cmd_o.flag=8'h09.
- Port 0 read at byte 0000_1000 -> mem_req_o never asserted, rvalid_o[0] at T+1 with err_o=1, flag=8'h02.
- Memory grants then never responds, TimeoutCycles=64 -> err_o=1 in the cycle after the counter reaches 63 (counter cleared at grant), flag=8'h04; a subsequent stray mem_rvalid_i produces no rvalid_o.
- rst_i pulsed during WAIT -> no rvalid_o/cmd_valid_o; next request after reset on port 1 alone is granted and completes normally.
